// File: rtl/ascon_arbiter_if.sv
// Bus bundle between the two requester adapters, the arbiter and the shared Ascon core.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface ascon_arbiter_if;
  logic         req_a_i, req_b_i;
  logic [127:0] key_a_i, key_b_i;
  logic [127:0] nonce_a_i, nonce_b_i;
  logic [63:0]  data_a_i, data_b_i;
  logic         data_valid_a_i, data_valid_b_i;
  logic         gnt_a_o, gnt_b_o;
  logic [63:0]  cipher_o;
  logic         cipher_valid_a_o, cipher_valid_b_o;
  logic [127:0] tag_o;
  logic         done_a_o, done_b_o;
  logic         error_o;
  logic         core_start_o;
  logic         core_data_valid_o;
  logic [63:0]  core_data_o;
  logic [127:0] core_key_o, core_nonce_o;
  logic [63:0]  core_cipher_i;
  logic         core_cipher_valid_i;
  logic [127:0] core_tag_i;
  logic         core_end_i;

  modport slave (
    input  req_a_i, req_b_i, key_a_i, key_b_i, nonce_a_i, nonce_b_i,
           data_a_i, data_b_i, data_valid_a_i, data_valid_b_i,
           core_cipher_i, core_cipher_valid_i, core_tag_i, core_end_i,
    output gnt_a_o, gnt_b_o, cipher_o, cipher_valid_a_o, cipher_valid_b_o,
           tag_o, done_a_o, done_b_o, error_o, core_start_o,
           core_data_valid_o, core_data_o, core_key_o, core_nonce_o
  );

  modport master (
    output req_a_i, req_b_i, key_a_i, key_b_i, nonce_a_i, nonce_b_i,
           data_a_i, data_b_i, data_valid_a_i, data_valid_b_i,
           core_cipher_i, core_cipher_valid_i, core_tag_i, core_end_i,
    input  gnt_a_o, gnt_b_o, cipher_o, cipher_valid_a_o, cipher_valid_b_o,
           tag_o, done_a_o, done_b_o, error_o, core_start_o,
           core_data_valid_o, core_data_o, core_key_o, core_nonce_o
  );
endinterface

// File: rtl/ascon_arbiter.sv
// Round-robin owner of a single Ascon-128 core shared by requesters A and B.
// Optional BUSY watchdog enabled by defining ASCON_ARB_TIMEOUT_EN.
module ascon_arbiter #(
  parameter bit PRIO    = 1'b0,
  parameter int TIMEOUT = 1023
) (
  input logic           clock_i,
  input logic           reset_i,
  ascon_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, START, BUSY, DONE} state_t;

  state_t state;
  logic   owner;  // 0 = A, 1 = B
  logic   last;   // last requester served
  logic   pick;

  // On a tie the requester not served last wins; otherwise whoever asks.
  assign pick = (bus.req_a_i && bus.req_b_i) ? ~last : bus.req_b_i;

  // Data path to the core is transparent for the owner only while BUSY.
  assign bus.core_data_valid_o = (state == BUSY) &&
                                 (owner ? bus.data_valid_b_i : bus.data_valid_a_i);
  assign bus.core_data_o       = (state != BUSY) ? 64'd0 :
                                 (owner ? bus.data_b_i : bus.data_a_i);

`ifdef ASCON_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  assign bus.error_o = 1'b0;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state                <= IDLE;
      owner                <= 1'b0;
      last                 <= ~PRIO;
      bus.gnt_a_o          <= 1'b0;
      bus.gnt_b_o          <= 1'b0;
      bus.core_start_o     <= 1'b0;
      bus.core_key_o       <= '0;
      bus.core_nonce_o     <= '0;
      bus.cipher_o         <= '0;
      bus.cipher_valid_a_o <= 1'b0;
      bus.cipher_valid_b_o <= 1'b0;
      bus.tag_o            <= '0;
      bus.done_a_o         <= 1'b0;
      bus.done_b_o         <= 1'b0;
`ifdef ASCON_ARB_TIMEOUT_EN
      bus.error_o          <= 1'b0;
      cnt                  <= '0;
`endif
    end else begin
      bus.core_start_o     <= 1'b0;
      bus.cipher_valid_a_o <= 1'b0;
      bus.cipher_valid_b_o <= 1'b0;
      bus.done_a_o         <= 1'b0;
      bus.done_b_o         <= 1'b0;
`ifdef ASCON_ARB_TIMEOUT_EN
      bus.error_o          <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.req_a_i || bus.req_b_i) begin
            owner            <= pick;
            bus.gnt_a_o      <= ~pick;
            bus.gnt_b_o      <= pick;
            bus.core_key_o   <= pick ? bus.key_b_i : bus.key_a_i;
            bus.core_nonce_o <= pick ? bus.nonce_b_i : bus.nonce_a_i;
            state            <= LOAD;
          end
        end
        LOAD: begin
          bus.core_start_o <= 1'b1;
          state            <= START;
        end
        START: begin
          state <= BUSY;
`ifdef ASCON_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        BUSY: begin
          if (bus.core_cipher_valid_i) begin
            bus.cipher_o         <= bus.core_cipher_i;
            bus.cipher_valid_a_o <= ~owner;
            bus.cipher_valid_b_o <= owner;
          end
          if (bus.core_end_i) begin
            bus.tag_o    <= bus.core_tag_i;
            bus.done_a_o <= ~owner;
            bus.done_b_o <= owner;
            state        <= DONE;
          end
`ifdef ASCON_ARB_TIMEOUT_EN
          // Last allowed BUSY cycle without an end: abort, tag left untouched.
          else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.error_o  <= 1'b1;
            bus.done_a_o <= ~owner;
            bus.done_b_o <= owner;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          last        <= owner;
          bus.gnt_a_o <= 1'b0;
          bus.gnt_b_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ascon_arbiter.md
Name: ascon_arbiter

Overview:
Shares one Ascon-128 core (ascon_top) between two independent requesters A and B.
- Round-robin arbitration.
- Latches the winner's key and nonce, pulses the core start, and forwards that requester's data blocks.
- Routes cipher and tag results back to the owner.
- Sits between the system bus adapters and the single core instance.

Parameters:
PRIO, 0, requester favoured after reset on simultaneous requests (0 = A, 1 = B)
TIMEOUT, 1023, watchdog limit in cycles for BUSY (used only with the optional feature)

Ports:
clock_i  in  1  system clock; one clock domain; all logic on rising edge
reset_i  in  1  reset, asynchronous and active-high
req_a_i / req_b_i  in  1  request core for one message
key_a_i / key_b_i  in  128  key of requester
nonce_a_i / nonce_b_i  in  128  nonce of requester
data_a_i / data_b_i  in  64  data block of requester
data_valid_a_i / data_valid_b_i  in  1  data block valid
gnt_a_o / gnt_b_o  out  1  ownership of core, held LOAD through DONE
cipher_o  out  64  cipher block, registered
cipher_valid_a_o / cipher_valid_b_o  out  1  cipher_o valid for that requester
tag_o  out  128  final tag, registered
done_a_o / done_b_o  out  1  one-cycle pulse: message finished, tag_o valid
error_o  out  1  one-cycle timeout pulse (tied 0 without the optional feature)
core_start_o  out  1  start pulse to core
core_data_valid_o  out  1  data valid to core
core_data_o  out  64  data to core
core_key_o / core_nonce_o  out  128  latched key/nonce to core
core_cipher_i  in  64  core cipher
core_cipher_valid_i  in  1  core cipher valid
core_tag_i  in  128  core tag
core_end_i  in  1  core end of message

Behaviour:
- Reset (any time, asynchronous): state IDLE; all outputs 0; key/nonce/tag/cipher registers 0; last-served pointer = !PRIO.
- Reset mid-message aborts the message: no done pulse and no partial tag. The core is reset by the same system reset.
- FSM states: IDLE -> LOAD -> START -> BUSY -> DONE -> IDLE.
- IDLE:
  - Exactly one request: grant it.
  - Both requests: grant the requester not last served.
  - No request: stay in IDLE.
- LOAD (1 cycle):
  - gnt_x_o rises.
  - Owner's key/nonce latched into core_key_o/core_nonce_o and held stable until the next LOAD.
  - Owner may change key/nonce afterwards.
- START (1 cycle): core_start_o = 1.
- Latency: request sampled in IDLE at cycle 0 -> gnt at cycle 1 -> core_start_o at cycle 2.
- BUSY:
  - core_data_o / core_data_valid_o follow the owner's data/data_valid combinationally.
  - Non-owner data_valid is ignored.
  - core_cipher_valid_i registers core_cipher_i into cipher_o and pulses the owner's cipher_valid_x_o one cycle later.
  - core_end_i registers core_tag_i into tag_o and moves to DONE.
  - core_cipher_valid_i and core_end_i in the same cycle: both are honoured.
- DONE (1 cycle):
  - Owner's done_x_o = 1 and tag_o is valid.
  - Last-served pointer is updated.
  - Grant drops on the transition to IDLE.
- Request deassertion during LOAD/START/BUSY is ignored; the grant holds until DONE.
- Request still high in IDLE after DONE is treated as a new message, subject to round-robin (A continuous + B pending -> B served next).
- core_end_i or core_cipher_valid_i outside BUSY: ignored, no outputs.
- Non-owner outputs (gnt, cipher_valid, done) stay 0 at all times.
- tag_o and cipher_o hold their last value until overwritten.

Optional Feature:
ASCON_ARB_TIMEOUT_EN:
- Defined: a counter of $clog2(TIMEOUT+1) bits clears on entering BUSY and increments each BUSY cycle.
  - Reaching TIMEOUT without core_end_i -> error_o pulses 1 cycle, go to DONE.
  - In that DONE, done_x_o still pulses and tag_o is not updated.
  - If core_end_i arrives in the same cycle the count reaches TIMEOUT, end wins and there is no error.
- Undefined: no counter; error_o tied 0; BUSY waits indefinitely.

Test Plan:
- Single request: req_a_i=1, key=0x000102..0F, nonce=0x101112..1F -> gnt_a_o at cycle 1; core_start_o pulse at cycle 2; core_key_o/core_nonce_o equal the inputs; done_a_o 1 cycle after core_end_i; tag_o = core_tag_i.
- Simultaneous requests after reset with PRIO=0 -> A served first, B second; repeat with A continuously requesting -> alternating A, B, A.
- Data routing: B owns the core; data_valid_a_i toggles with data_a_i=0xDEADBEEF -> core_data_valid_o follows only B. core_cipher_valid_i with core_cipher_i=0x0123456789ABCDEF -> cipher_o equals it, cipher_valid_b_o pulses, cipher_valid_a_o stays 0.
- Same-cycle core_cipher_valid_i and core_end_i -> cipher_valid pulse and done pulse both occur, tag_o updated.
- reset_i asserted asynchronously mid-BUSY -> all outputs 0 immediately, no done pulse; FSM in IDLE after release.
- With ASCON_ARB_TIMEOUT_EN and TIMEOUT=16, no core_end_i -> error_o and done pulse after 16 BUSY cycles, tag_o unchanged; without the macro, error_o stays 0.
